mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
- MEM-stage load/store unit of the Buceros core; sits between the ex_mem pipeline register and mem_wb.
- Issues data-bus transactions for loads and stores, stalls upstream stages until each access completes, and aligns and sign-extends load data.
- Passes non-memory ALU results straight through; its mem_wreg_* outputs feed mem_wb directly.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles spent in REQ+RESP before the access is aborted as a bus error (counter width = clog2(TIMEOUT_CYCLES+1)).
- REG_ADDR_W, 5, register address width.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- ex_mem_valid_i  in  1  instruction present in MEM stage.
- ex_ld_i  in  1  load op.
- ex_st_i  in  1  store op.
- ex_size_i  in  2  00 = byte, 01 = half, 10/11 = word.
- ex_unsigned_i  in  1  zero-extend load (LBU/LHU).
- ex_addr_i  in  32  effective address.
- ex_sdata_i  in  32  store data (rs2).
- ex_wreg_en_i  in  1  instruction writes rd.
- ex_wreg_addr_i  in  REG_ADDR_W  rd.
- ex_wreg_data_i  in  32  ALU result (non-load).
- dbus_req_o  out  1  bus request.
- dbus_we_o  out  1  1 = write.
- dbus_addr_o  out  32  word-aligned address ({addr[31:2],2'b00}).
- dbus_be_o  out  4  byte enables.
- dbus_wdata_o  out  32  lane-replicated store data.
- dbus_gnt_i  in  1  request accepted.
- dbus_rvalid_i  in  1  read data valid.
- dbus_rdata_i  in  32  read data.
- stall_o  out  1  hold for pc/if_id/id_ex/ex_mem.
- misalign_o  out  1  one-cycle misaligned-access pulse.
- bus_err_o  out  1  one-cycle timeout pulse.
- mem_wreg_en_o  out  1  to mem_wb.
- mem_wreg_addr_o  out  REG_ADDR_W  to mem_wb.
- mem_wreg_data_o  out  32  to mem_wb.

Behaviour:
- Clock/reset: single clock clk; reset rst is synchronous, active-high.
- Reset: state = IDLE, timeout counter = 0, all latched fields = 0. All outputs 0 in the reset cycle and the cycle after.
- Reset mid-transaction: dbus_req_o drops on the next edge; a late dbus_rvalid_i is ignored.
- Memory op = ex_mem_valid_i & (ex_ld_i | ex_st_i). If ld and st are both set, the op is a load.
- Misaligned = half with addr[0] = 1, or word with addr[1:0] != 0.
- IDLE:
  - Non-memory op or no valid op: mem_wreg_* = ex_wreg_* combinationally (en gated by ex_mem_valid_i); stall_o = 0.
  - Misaligned memory op: misalign_o = 1 for that cycle; no bus access; mem_wreg_en_o = 0; stall_o = 0.
  - Aligned memory op: stall_o = 1 and mem_wreg_en_o = 0. Latch we, dbus_addr, be, wdata, size, unsigned, addr[1:0], wreg_addr and wreg_en. Next state REQ.
- REQ: dbus_req_o = 1; addr, be, we and wdata held stable until gnt. On gnt: store goes to DONE, load goes to RESP. stall_o = 1.
- RESP: wait for dbus_rvalid_i (earliest one cycle after gnt). On rvalid, register the extracted data and go to DONE. stall_o = 1.
- Timeout: counter clears on entering REQ and increments each REQ/RESP cycle. When it reaches TIMEOUT_CYCLES: bus_err_o = 1 for one cycle, go to DONE with the writeback suppressed.
- DONE:
  - stall_o = 0.
  - mem_wreg_en_o = latched wreg_en & load & !timeout; addr = latched rd; data = load result.
  - Unconditional next state IDLE. The same held instruction is never re-issued.
- dbus_rvalid_i in IDLE, REQ or DONE is ignored.
- Load with gnt on the first REQ cycle and rvalid one cycle later: IDLE → REQ → RESP → DONE, i.e. 3 stall cycles, writeback in cycle 4.
- Store with immediate gnt: 2 stall cycles.
- Store lanes, with off = addr[1:0]:
  - Byte: be = 4'b0001 << off; wdata = {4{sdata[7:0]}}.
  - Half: be = 4'b0011 << off; wdata = {2{sdata[15:0]}}.
  - Word: be = 4'b1111; wdata = sdata.
- Load extract:
  - Byte: rdata[8*off +: 8].
  - Half: rdata[16*off[1] +: 16].
  - Word: rdata.
  - Sign-extend to 32 bits unless unsigned.

Test Plan:
- ALU op, ex_wreg_en_i = 1, rd = 5, data = 0x1234 -> same cycle mem_wreg_en_o = 1, addr = 5, data = 0x1234; stall_o = 0.
- LB addr 0x1003, rdata 0x80FF_FF7F, gnt immediate, rvalid next cycle -> stall_o high 3 cycles; DONE writes 0xFFFF_FF80. Same access as LBU -> 0x0000_0080.
- SH addr 0x2002, sdata 0xABCD_5678 -> dbus_addr 0x2000, be 4'b1100, wdata 0x5678_5678, we = 1; req held 3 cycles until gnt; no writeback.
- LW addr 0x3001 -> misalign_o pulses 1 cycle, dbus_req_o stays 0, stall_o = 0, mem_wreg_en_o = 0.
- LW, gnt never asserted, TIMEOUT_CYCLES = 4 -> bus_err_o pulse after 4 REQ cycles, then DONE with mem_wreg_en_o = 0, then IDLE.
- Assert rst during RESP, then rvalid -> dbus_req_o = 0, state IDLE, no writeback, stall_o = 0.

Source files
------------

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit. Issues one data-bus access per load/store,
//   stalls upstream until it completes, aligns/sign-extends load data and
//   passes non-memory results straight through to mem_wb.
// Ports: clk/rst (sync, active-high); ex_* from ex_mem; dbus_* request/grant/
//   rvalid data bus; stall/misalign/bus_err status; mem_wreg_* to mem_wb.
module mem_lsu #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int REG_ADDR_W     = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_mem_valid_i,
  input  logic                  ex_ld_i,
  input  logic                  ex_st_i,
  input  logic [1:0]            ex_size_i,
  input  logic                  ex_unsigned_i,
  input  logic [31:0]           ex_addr_i,
  input  logic [31:0]           ex_sdata_i,
  input  logic                  ex_wreg_en_i,
  input  logic [REG_ADDR_W-1:0] ex_wreg_addr_i,
  input  logic [31:0]           ex_wreg_data_i,
  output logic                  dbus_req_o,
  output logic                  dbus_we_o,
  output logic [31:0]           dbus_addr_o,
  output logic [3:0]            dbus_be_o,
  output logic [31:0]           dbus_wdata_o,
  input  logic                  dbus_gnt_i,
  input  logic                  dbus_rvalid_i,
  input  logic [31:0]           dbus_rdata_i,
  output logic                  stall_o,
  output logic                  misalign_o,
  output logic                  bus_err_o,
  output logic                  mem_wreg_en_o,
  output logic [REG_ADDR_W-1:0] mem_wreg_addr_o,
  output logic [31:0]           mem_wreg_data_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic                    rst_q;
  logic                    lat_we;
  logic [31:0]             lat_addr;
  logic [3:0]              lat_be;
  logic [31:0]             lat_wdata;
  logic [1:0]              lat_size;
  logic                    lat_uns;
  logic [1:0]              lat_off;
  logic [REG_ADDR_W-1:0]   lat_waddr;
  logic                    lat_wen;
  logic [31:0]             ld_data;
  logic                    timed_out;

  logic                    mem_op, misal, latch_en, capture, tmo_set, tmo_hit;
  logic [3:0]              be_calc;
  logic [31:0]             wdata_calc, ld_ext;

  assign mem_op  = ex_mem_valid_i & (ex_ld_i | ex_st_i);
  assign misal   = ((ex_size_i == 2'b01) & ex_addr_i[0]) |
                   (ex_size_i[1] & (ex_addr_i[1:0] != 2'b00));
  // Timeout fires on the TIMEOUT_CYCLES-th REQ/RESP cycle that makes no progress.
  assign tmo_hit = (cnt >= CW'(TIMEOUT_CYCLES - 1));

  // Store lane placement.
  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = ex_sdata_i;
    case (ex_size_i)
      2'b00: begin
        be_calc    = 4'b0001 << ex_addr_i[1:0];
        wdata_calc = {4{ex_sdata_i[7:0]}};
      end
      2'b01: begin
        be_calc    = 4'b0011 << ex_addr_i[1:0];
        wdata_calc = {2{ex_sdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction and extension.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b      = dbus_rdata_i[8*lat_off +: 8];
    h      = dbus_rdata_i[16*lat_off[1] +: 16];
    ld_ext = dbus_rdata_i;
    case (lat_size)
      2'b00:   ld_ext = {{24{b[7] & ~lat_uns}}, b};
      2'b01:   ld_ext = {{16{h[15] & ~lat_uns}}, h};
      default: ;
    endcase
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    latch_en        = 1'b0;
    capture         = 1'b0;
    tmo_set         = 1'b0;
    dbus_req_o      = 1'b0;
    dbus_we_o       = lat_we;
    dbus_addr_o     = lat_addr;
    dbus_be_o       = lat_be;
    dbus_wdata_o    = lat_wdata;
    stall_o         = 1'b0;
    misalign_o      = 1'b0;
    bus_err_o       = 1'b0;
    mem_wreg_en_o   = 1'b0;
    mem_wreg_addr_o = ex_wreg_addr_i;
    mem_wreg_data_o = ex_wreg_data_i;

    case (state)
      IDLE: begin
        // The cycle right after reset is kept quiet, so nothing is accepted.
        if (!rst_q) begin
          if (mem_op && misal) begin
            misalign_o = 1'b1;
          end else if (mem_op) begin
            stall_o   = 1'b1;
            latch_en  = 1'b1;
            cnt_nxt   = '0;
            state_nxt = REQ;
          end else begin
            mem_wreg_en_o = ex_mem_valid_i & ex_wreg_en_i;
          end
        end
      end
      REQ: begin
        dbus_req_o = 1'b1;
        stall_o    = 1'b1;
        cnt_nxt    = cnt + 1'b1;
        if (dbus_gnt_i) begin
          state_nxt = lat_we ? DONE : RESP;
        end else if (tmo_hit) begin
          bus_err_o = 1'b1;
          tmo_set   = 1'b1;
          state_nxt = DONE;
        end
      end
      RESP: begin
        stall_o = 1'b1;
        cnt_nxt = cnt + 1'b1;
        if (dbus_rvalid_i) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else if (tmo_hit) begin
          bus_err_o = 1'b1;
          tmo_set   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        mem_wreg_en_o   = lat_wen & ~lat_we & ~timed_out;
        mem_wreg_addr_o = lat_waddr;
        mem_wreg_data_o = ld_data;
        state_nxt       = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // All outputs read zero during reset and for one cycle after it.
    if (rst || rst_q) begin
      dbus_req_o      = 1'b0;
      dbus_we_o       = 1'b0;
      dbus_addr_o     = '0;
      dbus_be_o       = '0;
      dbus_wdata_o    = '0;
      stall_o         = 1'b0;
      misalign_o      = 1'b0;
      bus_err_o       = 1'b0;
      mem_wreg_en_o   = 1'b0;
      mem_wreg_addr_o = '0;
      mem_wreg_data_o = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rst_q     <= 1'b1;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_be    <= '0;
      lat_wdata <= '0;
      lat_size  <= '0;
      lat_uns   <= 1'b0;
      lat_off   <= '0;
      lat_waddr <= '0;
      lat_wen   <= 1'b0;
      ld_data   <= '0;
      timed_out <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rst_q <= 1'b0;
      if (latch_en) begin
        lat_we    <= ex_st_i & ~ex_ld_i;   // ld+st together is a load
        lat_addr  <= {ex_addr_i[31:2], 2'b00};
        lat_be    <= ex_ld_i ? 4'b1111 : be_calc;
        lat_wdata <= wdata_calc;
        lat_size  <= ex_size_i;
        lat_uns   <= ex_unsigned_i;
        lat_off   <= ex_addr_i[1:0];
        lat_waddr <= ex_wreg_addr_i;
        lat_wen   <= ex_wreg_en_i;
        timed_out <= 1'b0;
      end
      if (capture) ld_data   <= ld_ext;
      if (tmo_set) timed_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, ld, st, uns, wen;
  logic [1:0]  size;
  logic [31:0] addr, sdata, wdat;
  logic [4:0]  waddr;
  logic        gnt, rvalid;
  logic [31:0] rdata;
  logic        req, we, stall, mis, err, o_wen;
  logic [31:0] baddr, bwdata, o_wdat;
  logic [3:0]  be;
  logic [4:0]  o_waddr;

  mem_lsu #(.TIMEOUT_CYCLES(T), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .ex_mem_valid_i(valid), .ex_ld_i(ld), .ex_st_i(st),
    .ex_size_i(size), .ex_unsigned_i(uns), .ex_addr_i(addr), .ex_sdata_i(sdata),
    .ex_wreg_en_i(wen), .ex_wreg_addr_i(waddr), .ex_wreg_data_i(wdat),
    .dbus_req_o(req), .dbus_we_o(we), .dbus_addr_o(baddr), .dbus_be_o(be),
    .dbus_wdata_o(bwdata), .dbus_gnt_i(gnt), .dbus_rvalid_i(rvalid),
    .dbus_rdata_i(rdata), .stall_o(stall), .misalign_o(mis), .bus_err_o(err),
    .mem_wreg_en_o(o_wen), .mem_wreg_addr_o(o_waddr), .mem_wreg_data_o(o_wdat));

  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Expected outputs for the current cycle.
  logic        chk_on = 1'b0;
  logic        e_zero, e_stall, e_req, e_we, e_mis, e_err, e_wen;
  logic [31:0] e_addr, e_wdata, e_wdat;
  logic [3:0]  e_be;
  logic [4:0]  e_waddr;
  logic [31:0] last_wb = '0;
  int          run = 0, last_run = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [1:0] off);
    if (sz == 2'd0) return 4'(1 << off);
    if (sz == 2'd1) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wd(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_ld(input logic [31:0] r, input logic [1:0] sz,
                                           input logic u, input logic [1:0] off);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (r >> (8 * off)) & 32'hFF;
      if (!u && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (r >> (off >= 2 ? 16 : 0)) & 32'hFFFF;
      if (!u && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = r;
    end
    return v;
  endfunction

  // Single compare process.
  always @(negedge clk) begin
    if (chk_on) begin
      if (e_zero) begin
        chk("zero.req", 32'(req), 0);
        chk("zero.busfields", {we, be, baddr[7:0] ^ bwdata[7:0]} | 32'(|baddr) | 32'(|bwdata), 0);
        chk("zero.stat", {stall, mis, err, o_wen}, 0);
        chk("zero.wb", 32'(o_waddr) | o_wdat, 0);
      end else begin
        chk("stall", 32'(stall), 32'(e_stall));
        chk("req", 32'(req), 32'(e_req));
        chk("misalign", 32'(mis), 32'(e_mis));
        chk("bus_err", 32'(err), 32'(e_err));
        chk("wreg_en", 32'(o_wen), 32'(e_wen));
        if (e_req) begin
          chk("dbus_we", 32'(we), 32'(e_we));
          chk("dbus_addr", baddr, e_addr);
          chk("dbus_be", 32'(be), 32'(e_be));
          if (e_we) chk("dbus_wdata", bwdata, e_wdata);
        end
        if (e_wen) begin
          chk("wreg_addr", 32'(o_waddr), 32'(e_waddr));
          chk("wreg_data", o_wdat, e_wdat);
        end
      end
      if (o_wen) last_wb = o_wdat;
      if (stall) run++;
      else if (run != 0) begin last_run = run; run = 0; end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_exp();
    e_zero = 0; e_stall = 0; e_req = 0; e_we = 0; e_mis = 0; e_err = 0; e_wen = 0;
    e_addr = 0; e_wdata = 0; e_be = 0; e_waddr = 0; e_wdat = 0;
  endtask

  task automatic noise();
    rvalid = 1'($urandom_range(0, 1));
    rdata  = $urandom;
  endtask

  // One instruction held in MEM until it leaves; bus answers after gdel/rdel idle cycles.
  task automatic op(input logic v, l, s, input logic [1:0] sz, input logic u,
                    input logic [31:0] ad, sd, input logic we_r, input logic [4:0] wa,
                    input logic [31:0] wd, input int gdel, rdel, input logic [31:0] rd);
    logic memop, msa, is_ld, in_req, done, to;
    int k, kr;
    memop = v & (l | s);
    is_ld = l;
    msa   = (sz == 2'd1 && ad[0]) || (sz >= 2'd2 && ad[1:0] != 2'd0);
    valid = v; ld = l; st = s; size = sz; uns = u; addr = ad; sdata = sd;
    wen = we_r; waddr = wa; wdat = wd; gnt = 0; noise();
    clr_exp();
    e_stall = memop & ~msa;
    e_mis   = memop & msa;
    e_wen   = ~memop & v & we_r;
    e_waddr = wa; e_wdat = wd;
    next_cycle();
    if (!memop || msa) return;
    in_req = 1; done = 0; to = 0; k = 1; kr = 0;
    while (!done) begin
      clr_exp();
      e_stall = 1; e_req = in_req; e_we = ~is_ld;
      e_addr = {ad[31:2], 2'b00};
      e_be = is_ld ? 4'hF : model_be(sz, ad[1:0]);
      e_wdata = model_wd(sz, sd);
      gnt = 0; noise();
      if (in_req) begin
        if (k == gdel + 1) begin
          gnt = 1;
          if (!is_ld) done = 1;
          else begin in_req = 0; kr = k + rdel + 1; end
        end else if (k >= T) begin
          e_err = 1; to = 1; done = 1;
        end
      end else begin
        rvalid = 0;
        if (k == kr) begin rvalid = 1; rdata = rd; done = 1; end
        else if (k >= T) begin e_err = 1; to = 1; done = 1; end
      end
      next_cycle();
      k++;
    end
    clr_exp();
    gnt = 0; noise();
    e_wen = we_r & is_ld & ~to; e_waddr = wa; e_wdat = model_ld(rd, sz, u, ad[1:0]);
    next_cycle();
  endtask

  initial begin
    logic [1:0]  rsz;
    logic [31:0] rad;
    int kind, sel;
    // Model pins computed by hand.
    chk("pin.lb", model_ld(32'h80FF_FF7F, 2'd0, 1'b0, 2'd3), 32'hFFFF_FF80);
    chk("pin.lbu", model_ld(32'h80FF_FF7F, 2'd0, 1'b1, 2'd3), 32'h0000_0080);
    chk("pin.lh", model_ld(32'h8001_7FFF, 2'd1, 1'b0, 2'd2), 32'hFFFF_8001);
    chk("pin.be", 32'(model_be(2'd1, 2'd2)), 32'hC);
    chk("pin.wd", model_wd(2'd1, 32'hABCD_5678), 32'h5678_5678);

    rst = 1; valid = 0; ld = 0; st = 0; size = 0; uns = 0; addr = 0; sdata = 0;
    wen = 0; waddr = 0; wdat = 0; gnt = 0; rvalid = 0; rdata = 0;
    next_cycle();
    // Reset cycle and the one after: everything zero even with an ALU op present.
    valid = 1; wen = 1; waddr = 5'd7; wdat = 32'hDEAD_BEEF;
    clr_exp(); e_zero = 1; chk_on = 1;
    next_cycle();
    rst = 0;
    next_cycle();
    chk_on = 0; chk_on = 1;

    // Directed cases.
    op(1, 0, 0, 2'd2, 0, 32'h0, 32'h0, 1, 5'd5, 32'h1234, 0, 0, 0);
    chk("alu.wb_data", last_wb, 32'h1234);
    op(1, 1, 0, 2'd0, 0, 32'h1003, 32'h0, 1, 5'd9, 32'h0, 0, 0, 32'h80FF_FF7F);
    chk("lb.data", last_wb, 32'hFFFF_FF80);
    op(1, 0, 0, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lb.stall_cycles", last_run, 3);
    op(1, 1, 0, 2'd0, 1, 32'h1003, 32'h0, 1, 5'd9, 32'h0, 0, 0, 32'h80FF_FF7F);
    chk("lbu.data", last_wb, 32'h0000_0080);
    op(1, 0, 1, 2'd0, 0, 32'h40, 32'h11, 1, 5'd3, 32'h0, 0, 0, 0);
    op(0, 0, 0, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("st.stall_cycles", last_run, 2);
    op(1, 0, 1, 2'd1, 0, 32'h2002, 32'hABCD_5678, 1, 5'd4, 32'h0, 2, 0, 0);
    op(1, 1, 0, 2'd2, 0, 32'h3001, 32'h0, 1, 5'd6, 32'h0, 0, 0, 0);
    op(1, 1, 0, 2'd2, 0, 32'h3000, 32'h0, 1, 5'd6, 32'h0, 99, 0, 0);
    op(1, 1, 1, 2'd1, 0, 32'h3006, 32'h0, 1, 5'd8, 32'h0, 1, 1, 32'h8001_7FFF);
    chk("ldst.data", last_wb, 32'hFFFF_8001);

    // Reset while waiting for read data; the late rvalid must be dropped.
    op(1, 0, 0, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    valid = 1; ld = 1; st = 0; size = 2'd2; addr = 32'h4000; wen = 1; waddr = 5'd2;
    clr_exp(); e_stall = 1; next_cycle();
    clr_exp(); e_stall = 1; e_req = 1; e_addr = 32'h4000; e_be = 4'hF; gnt = 1; next_cycle();
    gnt = 0; rvalid = 0; rst = 1; clr_exp(); e_zero = 1; next_cycle();
    rst = 0; valid = 0; rvalid = 1; rdata = 32'h5555_AAAA; next_cycle();
    rvalid = 0; clr_exp(); next_cycle();
    clr_exp(); next_cycle();

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 9);
      rsz  = 2'($urandom_range(0, 3));
      rad  = $urandom;
      sel  = $urandom_range(0, 2);
      if (kind == 3) begin
        if (rsz == 2'd0) rsz = 2'd1;
        if (rsz == 2'd1) rad[0] = 1'b1;
        else rad[1:0] = 2'($urandom_range(1, 3));
      end else begin
        if (rsz == 2'd1) rad[0] = 1'b0;
        if (rsz >= 2'd2) rad[1:0] = 2'b00;
      end
      op(kind != 2, (kind >= 3) && sel != 1, (kind >= 3) && sel != 0, rsz,
         1'($urandom_range(0, 1)), rad, $urandom, 1'($urandom_range(0, 1)),
         5'($urandom), $urandom, $urandom_range(0, 4), $urandom_range(0, 4), $urandom);
    end

    chk_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
